// File: rtl/fc_outneuron_drain_2.sv
// fc_outneuron_drain_2: ordered readout of the FC2 output-neuron banks.
// Fetches one row (PO lanes) at a time, streams neurons in index order over a
// valid/ready interface and tracks the signed argmax of the accepted beats.
module fc_outneuron_drain_2 #(
    parameter int DATA_WIDTH_FC           = 16,
    parameter int PO                      = 4,
    parameter int OUTNEURON               = 136,
    parameter int FC_OUTNEURON_ADDR_WIDTH = 6,
    parameter int IDX_WIDTH               = 8,
    parameter int RD_LAT                  = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               start,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] outneuron_addr,
    output logic                               outneuron_rden,
    input  logic [DATA_WIDTH_FC*PO-1:0]        outneuron_q_all,
    output logic [DATA_WIDTH_FC-1:0]           out_data,
    output logic [IDX_WIDTH-1:0]               out_index,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [IDX_WIDTH-1:0]               argmax_index,
    output logic [DATA_WIDTH_FC-1:0]           argmax_value,
    output logic                               busy,
    output logic                               done
);

    localparam int ROWS   = OUTNEURON / PO;
    localparam int ROW_W  = FC_OUTNEURON_ADDR_WIDTH;
    localparam int LANE_W = (PO > 1) ? $clog2(PO) : 1;
    localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]         row_q;
    logic [LANE_W-1:0]        lane_q;
    logic [LANE_W-1:0]        lane_nxt;
    logic [WCNT_W-1:0]        wcnt_q;
    logic [DATA_WIDTH_FC-1:0] row_buf_q [PO];

    logic                     rden_q;
    logic [DATA_WIDTH_FC-1:0] data_q;
    logic [IDX_WIDTH-1:0]     index_q;
    logic                     valid_q;
    logic [IDX_WIDTH-1:0]     amax_idx_q;
    logic [DATA_WIDTH_FC-1:0] amax_val_q;
    logic                     busy_q;
    logic                     done_q;

    logic start_acc;
    logic wait_done;
    logic hs;
    logic last_lane;
    logic last_row;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle event strobes (all gated by enable)
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        wait_done = 1'b0;
        hs        = 1'b0;
        last_lane = (lane_q == LANE_W'(PO - 1));
        last_row  = (row_q == ROW_W'(ROWS - 1));
        lane_nxt  = lane_q + 1'b1;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (wcnt_q == WCNT_W'(RD_LAT - 1)) begin
                        wait_done = 1'b1;
                        state_d   = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        hs = 1'b1;
                        if (last_lane) begin
                            state_d = last_row ? S_FIN : S_FETCH;
                        end
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: counters, row buffer, registered stream and argmax outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q      <= '0;
            lane_q     <= '0;
            wcnt_q     <= '0;
            for (int unsigned k = 0; k < PO; k++) begin
                row_buf_q[k] <= '0;
            end
            rden_q     <= 1'b0;
            data_q     <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            amax_idx_q <= '0;
            amax_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (enable) begin
            // Read strobe and done pulse are registered from the upcoming state
            rden_q <= (state_d == S_FETCH);
            done_q <= (state_d == S_FIN);

            if (state_q == S_WAIT && !wait_done) begin
                wcnt_q <= wcnt_q + 1'b1;
            end else begin
                wcnt_q <= '0;
            end

            if (start_acc) begin
                busy_q     <= 1'b1;
                row_q      <= '0;
                amax_idx_q <= '0;
                amax_val_q <= '0;
            end else if (state_q == S_FIN) begin
                busy_q <= 1'b0;
            end

            // Lane 0 is forwarded straight from the bank bus on the capture edge
            if (wait_done) begin
                for (int unsigned k = 0; k < PO; k++) begin
                    row_buf_q[k] <= outneuron_q_all[k*DATA_WIDTH_FC +: DATA_WIDTH_FC];
                end
                lane_q  <= '0;
                valid_q <= 1'b1;
                data_q  <= outneuron_q_all[DATA_WIDTH_FC-1:0];
                index_q <= IDX_WIDTH'(row_q) * IDX_WIDTH'(PO);
            end

            if (hs) begin
                if (index_q == '0 || $signed(data_q) > $signed(amax_val_q)) begin
                    amax_idx_q <= index_q;
                    amax_val_q <= data_q;
                end
                if (!last_lane) begin
                    lane_q  <= lane_nxt;
                    data_q  <= row_buf_q[lane_nxt];
                    index_q <= index_q + 1'b1;
                end else begin
                    valid_q <= 1'b0;
                    if (!last_row) begin
                        row_q <= row_q + 1'b1;
                    end
                end
            end
        end
    end

    assign outneuron_addr = row_q;
    assign outneuron_rden = rden_q;
    assign out_data       = data_q;
    assign out_index      = index_q;
    assign out_valid      = valid_q;
    assign argmax_index   = amax_idx_q;
    assign argmax_value   = amax_val_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_fc_outneuron_drain_2.sv
// Self-checking bench for fc_outneuron_drain_2: a scoreboard queue filled from a
// neuron-order reference array, a negedge monitor, and a banked RAM model.
module tb_fc_outneuron_drain_2;

    localparam int W      = 16;
    localparam int PO     = 4;
    localparam int N      = 136;
    localparam int AW     = 6;
    localparam int IW     = 8;
    localparam int RD_LAT = 2;

    typedef struct {
        int         idx;
        logic [W-1:0] data;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          start;
    logic          out_ready;
    logic [AW-1:0] outneuron_addr;
    logic          outneuron_rden;
    logic [W*PO-1:0] outneuron_q_all;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          out_valid;
    logic [IW-1:0] argmax_index;
    logic [W-1:0]  argmax_value;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int last_hs_cnt = 0;

    beat_t exp_q[$];
    logic [W-1:0] nmem [N];
    logic [W*PO-1:0] p1 = '0;
    logic [W*PO-1:0] p2 = '0;

    fc_outneuron_drain_2 #(
        .DATA_WIDTH_FC(W),
        .PO(PO),
        .OUTNEURON(N),
        .FC_OUTNEURON_ADDR_WIDTH(AW),
        .IDX_WIDTH(IW),
        .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .start(start),
        .outneuron_addr(outneuron_addr),
        .outneuron_rden(outneuron_rden),
        .outneuron_q_all(outneuron_q_all),
        .out_data(out_data),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .argmax_index(argmax_index),
        .argmax_value(argmax_value),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    // Bank model: neuron n lives in bank n%PO at address n/PO, two-stage read
    always @(posedge clock) begin
        if (outneuron_rden) begin
            for (int k = 0; k < PO; k++) begin
                p1[k*W +: W] <= nmem[int'(outneuron_addr) * PO + k];
            end
        end
        p2 <= p1;
        cyc_cnt <= cyc_cnt + 1;
    end
    assign outneuron_q_all = p2;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sval(input int n);
        int v;
        v = $signed(nmem[n]);
        return v;
    endfunction

    // Monitor: scoreboard pop on handshake, stability while stalled, done timing
    bit stalled = 1'b0;
    int hold_idx = 0;
    int hold_data = 0;
    always @(negedge clock) begin
        beat_t e;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_index", int'(out_index), hold_idx);
                check("stall_data", int'(out_data), hold_data);
            end
            if (done) check("done_after_last_hs", cyc_cnt, last_hs_cnt);
            if (out_valid && out_ready && enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got index %0d expected no beat", out_index);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_index", int'(out_index), e.idx);
                    check("beat_data", int'(out_data), int'(e.data));
                end
                last_hs_cnt = cyc_cnt + 1;
            end
            stalled   = out_valid && !(out_ready && enable);
            hold_idx  = int'(out_index);
            hold_data = int'(out_data);
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"}, int'(outneuron_addr), 0);
        check({tag, "_rden"}, int'(outneuron_rden), 0);
        check({tag, "_data"}, int'(out_data), 0);
        check({tag, "_index"}, int'(out_index), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_amax_idx"}, int'(argmax_index), 0);
        check({tag, "_amax_val"}, int'(argmax_value), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // mode 0: ready high; 1: random ready at duty%; 2: restart at beat 20 and
    // 10-cycle enable drop at beat 60; 3: reset during beat 50
    task automatic drain(input int mode, input int duty, input int exp_cyc);
        beat_t b;
        int cyc, first_valid, stall_left, mx, mi;
        bit restarted, stalled_once, aborted;
        for (int n = 0; n < N; n++) begin
            b.idx  = n;
            b.data = nmem[n];
            exp_q.push_back(b);
        end
        mx = -100000;
        for (int n = 0; n < N; n++) if (sval(n) > mx) mx = sval(n);
        mi = -1;
        for (int n = 0; n < N; n++) if (mi < 0 && sval(n) == mx) mi = n;

        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        cyc = 1; first_valid = 0; stall_left = 0;
        restarted = 1'b0; stalled_once = 1'b0; aborted = 1'b0;
        while (!done && cyc < 5000 && !aborted) begin
            out_ready = (mode == 1) ? ($urandom_range(0, 99) < duty) : 1'b1;
            start = 1'b0;
            if (mode == 2 && out_valid && out_index == 20 && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (mode == 2 && out_valid && out_index == 60 && !stalled_once) begin
                stall_left = 10;
                stalled_once = 1'b1;
            end
            enable = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (mode == 3 && out_valid && out_index == 50) begin
                reset = 1'b1;
                #1;
                check_outputs_zero("midreset");
                exp_q.delete();
                @(posedge clock); #1;
                reset = 1'b0;
                aborted = 1'b1;
            end else begin
                @(posedge clock); #1;
                cyc++;
                if (out_valid && first_valid == 0) first_valid = cyc;
            end
        end
        start = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        if (!aborted) begin
            check("drain_timeout", int'(cyc < 5000), 1);
            if (exp_cyc > 0) check("done_cycle", cyc, exp_cyc);
            check("first_valid_cycle", first_valid, 4);
            check("beats_missing", exp_q.size(), 0);
            check("argmax_index", int'(argmax_index), mi);
            check("argmax_value", int'($signed(argmax_value)), mx);
            @(posedge clock); #1;
            check("done_pulse_end", int'(done), 0);
            check("busy_after_done", int'(busy), 0);
            check("argmax_hold", int'(argmax_index), mi);
        end
        exp_q.delete();
    endtask

    initial begin
        int v;
        reset = 1'b1;
        enable = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int n = 0; n < N; n++) nmem[n] = W'(n);
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Ramp, full throughput
        drain(0, 0, 239);
        // Ramp under backpressure
        drain(1, 25, 0);
        drain(1, 60, 0);

        // Signed extremes and ties
        for (int n = 0; n < N; n++) nmem[n] = 16'hFFFB;
        nmem[17] = 16'h7FFF;
        nmem[90] = 16'h7FFF;
        nmem[3]  = 16'h8000;
        drain(0, 0, 239);
        check("ties_index", int'(argmax_index), 17);
        check("ties_value", int'(argmax_value), 32'h7FFF);

        // Random data with random backpressure
        for (int n = 0; n < N; n++) nmem[n] = W'($urandom);
        drain(1, 50, 0);

        // Reset mid-drain, then a fresh pass whose argmax must ignore the aborted one
        for (int n = 0; n < N; n++) nmem[n] = W'($urandom_range(0, 100));
        nmem[10] = 16'h7FFF;
        drain(3, 0, 0);
        for (int n = 0; n < N; n++) begin
            v = int'($urandom_range(0, 2000)) - 1000;
            nmem[n] = v[W-1:0];
        end
        drain(0, 0, 239);

        // Start while busy plus a 10-cycle enable stall
        for (int n = 0; n < N; n++) nmem[n] = W'($urandom);
        drain(2, 0, 249);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_outneuron_drain_2.md
# fc_outneuron_drain_2

Downstream stage of the second fully-connected layer. Once the layer finishes, this block reads its PO output-neuron RAM banks, serialises all OUTNEURON results in neuron-index order over a valid/ready stream, and tracks the signed maximum value and its index (argmax). It replaces ad-hoc probing of lane 0 with a complete, ordered readout for the landmark/regression consumer.

## Interface
Parameters:
- DATA_WIDTH_FC, 16, width of one stored neuron, signed two's complement
- PO, 4, number of output-neuron banks (parallel lanes)
- OUTNEURON, 136, total output neurons; must be a multiple of PO
- FC_OUTNEURON_ADDR_WIDTH, 6, bank address width; must satisfy 2^width ≥ OUTNEURON/PO
- IDX_WIDTH, 8, neuron index width; must satisfy 2^IDX_WIDTH ≥ OUTNEURON
- RD_LAT, 2, bank read latency in cycles from rden sample to valid q (≥1)

Ports:
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- enable  in  1  stall control; low freezes the FSM and all counters
- start  in  1  one-cycle pulse, driven by the FC layer's done
- outneuron_addr  out  FC_OUTNEURON_ADDR_WIDTH  shared read address to all banks
- outneuron_rden  out  1  shared read enable to all banks
- outneuron_q_all  in  DATA_WIDTH_FC*PO  bank outputs concatenated; lane k at bits [k*W+W-1 : k*W]
- out_data  out  DATA_WIDTH_FC  current neuron value
- out_index  out  IDX_WIDTH  neuron index of out_data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- argmax_index  out  IDX_WIDTH  index of the maximum neuron
- argmax_value  out  DATA_WIDTH_FC  maximum neuron value
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final handshake

## Operation
- Mapping: neuron n is stored in bank n mod PO at address n / PO. Rows = OUTNEURON/PO (34 by default).
- FSM states: IDLE, FETCH, WAIT, EMIT, FIN.
- IDLE: start=1 and enable=1 → FETCH; row counter = 0; argmax cleared. start in any other state is ignored.
- FETCH (1 cycle): outneuron_rden=1, outneuron_addr=row → WAIT.
- WAIT (RD_LAT cycles): on the final WAIT edge, capture all PO lanes of outneuron_q_all into a row buffer → EMIT with lane = 0.
- EMIT: out_valid=1, out_data=buffer[lane], out_index=row*PO+lane. On out_valid & out_ready: update argmax, then lane+1. After lane PO-1: if row is the last row → FIN, otherwise row+1 → FETCH.
- FIN (1 cycle): done=1 → IDLE. argmax outputs hold until the next accepted start.
- Argmax: signed compare. The first neuron (index 0) loads unconditionally. Later neurons replace the stored maximum only if strictly greater, so ties keep the lowest index.
- Stream rule: while out_valid=1 and out_ready=0, out_data and out_index are held stable and out_valid stays high.
- enable=0: state, counters, row buffer, and the RD_LAT pipeline counter are frozen, and outputs hold their values. Bank read data is not re-sampled, so hold enable high from FETCH through WAIT.
- The block never writes the banks; wren is tied off outside this block.

## Timing
- Reset values: outneuron_addr=0, outneuron_rden=0, out_data=0, out_index=0, out_valid=0, argmax_index=0, argmax_value=0, busy=0, done=0; state=IDLE.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronously) and discards the partial argmax. After reset, the block waits for a fresh start.
- Start sampled at edge 0: FETCH in cycle 1, WAIT in cycles 2–3 (RD_LAT=2), first out_valid in cycle 4.
- With out_ready held high, each row costs 1 + RD_LAT + PO cycles (7). A default full drain is 34 × 7 = 238 cycles, with done in cycle 239.
- All outputs are registered. There is no combinational path from out_ready to out_valid or out_data.
- A row buffer refill never overlaps with EMIT; the next row is fetched only after the last lane of the current row is accepted.

## Test plan
- Ramp: bank k, address a holds a*PO+k. out_ready=1, pulse start → 136 beats with out_data = out_index = 0..135; argmax_index=135, argmax_value=135; done in cycle 239 after start.
- Backpressure: same data, out_ready toggled pseudo-randomly (as low as 25% duty) → identical sequence with no drops or duplicates; out_data stable while stalled; done fires 1 cycle after the 136th handshake.
- Signed and ties: all neurons = -5 except neurons 17 and 90 = 0x7FFF, neuron 3 = 0x8000 → argmax_index=17, argmax_value=0x7FFF.
- Reset mid-drain: assert reset during beat 50 → all outputs are 0 the same cycle; a new start replays from index 0, and argmax reflects only the new pass.
- Start while busy, plus enable stall: pulse start again at beat 20 → ignored, sequence unaffected. Drop enable for 10 cycles during EMIT → out_valid held, no beat lost, total time extends by exactly 10 cycles.
